// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus bundle for cpu_bus_responder: address/data/direction from
// the CPU, read data and the two active-low interrupt lines back to it.
interface cpu_bus_responder_if;
    logic [15:0] Addr_bus;
    logic [7:0]  Data_bus_out;
    logic        R_nW;
    logic [7:0]  Data_bus_in;
    logic        irq;
    logic        nmi;

    modport master (
        output Addr_bus, Data_bus_out, R_nW,
        input  Data_bus_in, irq, nmi
    );

    modport slave (
        input  Addr_bus, Data_bus_out, R_nW,
        output Data_bus_in, irq, nmi
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: memory-mapped target for a 6502-style CPU.
//   $0000-$1FFF  2 KiB RAM, mirrored every $0800
//   $4020-$4023  interval timer (RELOAD lo/hi, CTRL, STATUS)
//   $4024        NMI pulse trigger (write only)
//   $FFFA-$FFFF  NMI / reset / IRQ vectors
// Reads are combinational; writes commit on the rising edge of clk_ph2.
// Optional feature: define CPU_BUS_RESPONDER_TIMER_EN to build the timer;
// without it the timer registers read 0 and irq stays high.
module cpu_bus_responder #(
    parameter logic [15:0] RST_VEC   = 16'h0000,
    parameter logic [15:0] NMI_VEC   = 16'h2000,
    parameter logic [15:0] IRQ_VEC   = 16'h2000,
    parameter logic [7:0]  NMI_PULSE = 8'd15
) (
    input logic                clk_ph2,
    input logic                rst,
    cpu_bus_responder_if.slave bus
);
    logic       w_wr;
    logic       w_sel_ram;
    logic [7:0] w_rd_data;
    logic [7:0] w_timer_rd;
    logic [7:0] w_nmi_cnt_nxt;
    logic [7:0] r_nmi_cnt;
    logic       r_nmi;
    logic [7:0] r_ram [0:2047];

    assign w_wr      = ~bus.R_nW;
    assign w_sel_ram = (bus.Addr_bus < 16'h2000);

    // RAM write port; contents deliberately not reset
    always_ff @(posedge clk_ph2) begin
        if (w_wr && w_sel_ram) begin
            r_ram[bus.Addr_bus[10:0]] <= bus.Data_bus_out;
        end
    end

    // NMI pulse counter next value: a write (re)loads, otherwise count down to 0
    always_comb begin
        w_nmi_cnt_nxt = r_nmi_cnt;
        if (w_wr && (bus.Addr_bus == 16'h4024)) begin
            w_nmi_cnt_nxt = NMI_PULSE;
        end else if (r_nmi_cnt != 8'd0) begin
            w_nmi_cnt_nxt = r_nmi_cnt - 8'd1;
        end
    end

    // NMI counter and registered nmi line, derived from the next count so the
    // pulse starts on the trigger edge and a re-trigger never lets nmi go high
    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            r_nmi_cnt <= 8'd0;
            r_nmi     <= 1'b1;
        end else begin
            r_nmi_cnt <= w_nmi_cnt_nxt;
            r_nmi     <= (w_nmi_cnt_nxt == 8'd0);
        end
    end

    assign bus.nmi = r_nmi;

`ifdef CPU_BUS_RESPONDER_TIMER_EN
    logic [15:0] r_reload, w_reload_nxt;
    logic [15:0] r_count,  w_count_nxt;
    logic        r_en,   w_en_nxt;
    logic        r_auto, w_auto_nxt;
    logic        r_ien,  w_ien_nxt;
    logic        r_pend, w_pend_nxt;
    logic        r_irq;
    logic        w_expire;

    assign w_expire = r_en && (r_count == 16'd0);

    // Timer next state: count/expiry first, then a bus write overrides;
    // an expiry on the same edge as a STATUS clear keeps PEND set
    always_comb begin
        w_reload_nxt = r_reload;
        w_count_nxt  = r_count;
        w_en_nxt     = r_en;
        w_auto_nxt   = r_auto;
        w_ien_nxt    = r_ien;
        w_pend_nxt   = r_pend;
        if (r_en) begin
            if (w_expire) begin
                w_pend_nxt = 1'b1;
                if (r_auto) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_en_nxt = 1'b0;
                end
            end else begin
                w_count_nxt = r_count - 16'd1;
            end
        end
        if (w_wr) begin
            case (bus.Addr_bus)
                16'h4020: w_reload_nxt[7:0]  = bus.Data_bus_out;
                16'h4021: w_reload_nxt[15:8] = bus.Data_bus_out;
                16'h4022: begin
                    w_en_nxt   = bus.Data_bus_out[0];
                    w_auto_nxt = bus.Data_bus_out[1];
                    w_ien_nxt  = bus.Data_bus_out[2];
                    if (bus.Data_bus_out[0]) begin
                        w_count_nxt = r_reload;
                    end
                end
                16'h4023: begin
                    if (!w_expire) begin
                        w_pend_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timer registers; irq registered from the next PEND/IEN
    always_ff @(posedge clk_ph2 or negedge rst) begin
        if (!rst) begin
            r_reload <= 16'd0;
            r_count  <= 16'd0;
            r_en     <= 1'b0;
            r_auto   <= 1'b0;
            r_ien    <= 1'b0;
            r_pend   <= 1'b0;
            r_irq    <= 1'b1;
        end else begin
            r_reload <= w_reload_nxt;
            r_count  <= w_count_nxt;
            r_en     <= w_en_nxt;
            r_auto   <= w_auto_nxt;
            r_ien    <= w_ien_nxt;
            r_pend   <= w_pend_nxt;
            r_irq    <= ~(w_pend_nxt & w_ien_nxt);
        end
    end

    // Timer register readback
    always_comb begin
        w_timer_rd = 8'h00;
        case (bus.Addr_bus)
            16'h4020: w_timer_rd = r_reload[7:0];
            16'h4021: w_timer_rd = r_reload[15:8];
            16'h4022: w_timer_rd = {5'b00000, r_ien, r_auto, r_en};
            16'h4023: w_timer_rd = {r_pend, 7'b0000000};
            default:  w_timer_rd = 8'h00;
        endcase
    end

    assign bus.irq = r_irq;
`else
    assign w_timer_rd = 8'h00;
    assign bus.irq    = 1'b1;
`endif

    // Read data mux; anything not decoded reads 0
    always_comb begin
        w_rd_data = 8'h00;
        if (w_sel_ram) begin
            w_rd_data = r_ram[bus.Addr_bus[10:0]];
        end else begin
            case (bus.Addr_bus)
                16'hFFFA: w_rd_data = NMI_VEC[7:0];
                16'hFFFB: w_rd_data = NMI_VEC[15:8];
                16'hFFFC: w_rd_data = RST_VEC[7:0];
                16'hFFFD: w_rd_data = RST_VEC[15:8];
                16'hFFFE: w_rd_data = IRQ_VEC[7:0];
                16'hFFFF: w_rd_data = IRQ_VEC[15:8];
                default:  w_rd_data = w_timer_rd;
            endcase
        end
    end

    assign bus.Data_bus_in = w_rd_data;
endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder. The driver updates an event-level
// reference model (timer expiry scheduled as absolute edge numbers, NMI as a
// "low until edge" mark) and queues expected read data and irq/nmi levels;
// two monitors pop and compare against the DUT.
module tb_cpu_bus_responder;
`ifdef CPU_BUS_RESPONDER_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam int PULSE = 15;

    logic clk_ph2 = 1'b0;
    logic rst     = 1'b0;
    cpu_bus_responder_if bus();

    cpu_bus_responder dut (.clk_ph2(clk_ph2), .rst(rst), .bus(bus));

    always #5 clk_ph2 = ~clk_ph2;

    int tests = 0;
    int fails = 0;

    // reference model state
    int          edge_n = 0;
    int          m_reload, m_next_exp, m_nmi_until;
    bit          m_en, m_auto, m_ien, m_pend;
    logic [7:0]  m_ram [0:2047];
    int          ram_idx_q[$];

    logic [7:0]  rd_exp_q[$];
    logic [15:0] rd_addr_q[$];
    logic [1:0]  st_exp_q[$];
    bit          rd_pending = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        logic [15:0] r;
        r = m_reload[15:0];
        if (a < 16'h2000) return m_ram[a[10:0]];
        case (a)
            16'hFFFA: return 8'h00;
            16'hFFFB: return 8'h20;
            16'hFFFC: return 8'h00;
            16'hFFFD: return 8'h00;
            16'hFFFE: return 8'h00;
            16'hFFFF: return 8'h20;
            default: ;
        endcase
        if (TIMER) begin
            case (a)
                16'h4020: return r[7:0];
                16'h4021: return r[15:8];
                16'h4022: return {5'b0, m_ien, m_auto, m_en};
                16'h4023: return {m_pend, 7'b0};
                default: ;
            endcase
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_reload = 0; m_next_exp = 0; m_nmi_until = 0;
        m_en = 0; m_auto = 0; m_ien = 0; m_pend = 0;
        ram_idx_q.delete();
    endtask

    task automatic model_step(input int e, input bit wr, input logic [15:0] a, input logic [7:0] d);
        bit expired;
        expired = 1'b0;
        if (TIMER && m_en && (e == m_next_exp)) begin
            expired = 1'b1;
            m_pend  = 1'b1;
            if (m_auto) m_next_exp = e + m_reload + 1;
            else        m_en = 1'b0;
        end
        if (wr) begin
            if (a < 16'h2000) begin
                m_ram[a[10:0]] = d;
                ram_idx_q.push_back(int'(a[10:0]));
            end else if (a == 16'h4024) begin
                m_nmi_until = e + PULSE;
            end else if (TIMER) begin
                case (a)
                    16'h4020: m_reload = (m_reload & 32'hFF00) | int'(d);
                    16'h4021: m_reload = (m_reload & 32'h00FF) | (int'(d) << 8);
                    16'h4022: begin
                        m_en = d[0]; m_auto = d[1]; m_ien = d[2];
                        if (d[0]) m_next_exp = e + m_reload + 1;
                    end
                    16'h4023: if (!expired) m_pend = 1'b0;
                    default: ;
                endcase
            end
        end
    endtask

    // one bus cycle: drive at negedge, commit on the following rising edge
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input bit rnw);
        @(negedge clk_ph2);
        rst = 1'b1;
        bus.Addr_bus = a; bus.Data_bus_out = d; bus.R_nW = rnw;
        rd_pending = rnw;
        if (rnw) begin
            rd_exp_q.push_back(model_read(a));
            rd_addr_q.push_back(a);
        end
        edge_n++;
        model_step(edge_n, !rnw, a, d);
        st_exp_q.push_back({~(m_pend & m_ien), (edge_n < m_nmi_until) ? 1'b0 : 1'b1});
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_cycle(a, d, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a);
        bus_cycle(a, 8'h00, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rd(16'h3000);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_ph2);
            rst = 1'b0;
            rd_pending = 1'b0;
            bus.Addr_bus = 16'h3000; bus.Data_bus_out = 8'h00; bus.R_nW = 1'b1;
            model_reset();
            edge_n++;
            st_exp_q.push_back(2'b11);
        end
    endtask

    // read-data monitor: sample mid-cycle, well before the commit edge
    initial begin
        forever begin
            @(negedge clk_ph2);
            #2;
            if (rd_pending && rd_exp_q.size() > 0) begin
                logic [15:0] a;
                a = rd_addr_q.pop_front();
                chk($sformatf("rd[%04h]", a), {8'h00, bus.Data_bus_in}, {8'h00, rd_exp_q.pop_front()});
            end
        end
    end

    // interrupt-line monitor: sample just after each edge
    initial begin
        forever begin
            @(posedge clk_ph2);
            #1;
            if (st_exp_q.size() > 0) begin
                logic [1:0] s;
                s = st_exp_q.pop_front();
                chk($sformatf("irq@%0d", $time), {15'd0, bus.irq}, {15'd0, s[1]});
                chk($sformatf("nmi@%0d", $time), {15'd0, bus.nmi}, {15'd0, s[0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Addr_bus = 16'h3000; bus.Data_bus_out = 8'h00; bus.R_nW = 1'b1;
        model_reset();
        reset_cycles(2);

        // RAM mirroring and unmapped read
        wr(16'h0012, 8'h55);
        rd(16'h0812); rd(16'h1812); rd(16'h0012); rd(16'h2000);

        // vectors, writes to them ignored
        for (int a = 16'hFFFA; a <= 16'hFFFF; a++) rd(a[15:0]);
        wr(16'hFFFA, 8'hAB);
        rd(16'hFFFA);

        // one-shot timer with IEN
        wr(16'h4020, 8'h03); wr(16'h4021, 8'h00);
        rd(16'h4020); rd(16'h4021);
        wr(16'h4022, 8'h05);
        for (int i = 0; i < 6; i++) rd(16'h4022);
        rd(16'h4023);
        wr(16'h4023, 8'h00);
        idle(2); rd(16'h4023);

        // auto-reload, clear on the expiry edge
        wr(16'h4020, 8'h01);
        wr(16'h4022, 8'h07);
        idle(1);
        wr(16'h4023, 8'hFF);
        rd(16'h4023); idle(2);
        wr(16'h4022, 8'h00);
        wr(16'h4023, 8'h00);
        rd(16'h4023);

        // RELOAD=0 with AUTO: PEND every clock; IEN=0 masks
        wr(16'h4020, 8'h00);
        wr(16'h4022, 8'h03);
        wr(16'h4023, 8'h00);
        rd(16'h4023); idle(2);
        wr(16'h4022, 8'h00); wr(16'h4023, 8'h00);

        // NMI pulse and re-trigger
        wr(16'h4024, 8'h00);
        idle(20);
        wr(16'h4024, 8'h00);
        idle(9);
        wr(16'h4024, 8'h00);
        rd(16'h4024);
        idle(28);

        // reset mid-count and mid-pulse
        wr(16'h4020, 8'h10);
        wr(16'h4022, 8'h05);
        wr(16'h4024, 8'h00);
        idle(4);
        reset_cycles(2);
        rd(16'h4022); rd(16'h4020);
        idle(30);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int k;
            k = $urandom_range(0, 11);
            case (k)
                0, 1: wr({3'b000, 13'($urandom_range(0, 16'h1FFF))}, 8'($urandom));
                2, 3: begin
                    if (ram_idx_q.size() > 0) begin
                        int idx;
                        logic [1:0] m;
                        idx = ram_idx_q[$urandom_range(0, ram_idx_q.size() - 1)];
                        m = 2'($urandom);
                        rd({3'b000, m, idx[10:0]});
                    end else begin
                        rd(16'h5000);
                    end
                end
                4: wr(16'h4020, 8'($urandom_range(0, 6)));
                5: wr(16'h4021, ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00);
                6: wr(16'h4022, 8'($urandom));
                7: wr(16'h4023, 8'($urandom));
                8: if ($urandom_range(0, 3) == 0) wr(16'h4024, 8'($urandom)); else idle(1);
                9: rd(16'h4020 + 16'($urandom_range(0, 4)));
                10: rd(16'hFFFA + 16'($urandom_range(0, 5)));
                default: begin
                    if ($urandom_range(0, 1) == 1) wr(16'h6000 + 16'($urandom), 8'($urandom));
                    else rd(16'h4025 + 16'($urandom_range(0, 200)));
                end
            endcase
        end
        idle(2);
        @(negedge clk_ph2);
        @(negedge clk_ph2);
        #3;
        chk("rd_queue_drained", 16'(rd_exp_q.size()), 16'd0);
        chk("st_queue_drained", 16'(st_exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 The block SHALL expose parameter RST_VEC, default 16'h0000, reset vector returned at $FFFC/$FFFD.
REQ-002 The block SHALL expose parameter NMI_VEC, default 16'h2000, NMI vector returned at $FFFA/$FFFB.
REQ-003 The block SHALL expose parameter IRQ_VEC, default 16'h2000, IRQ/BRK vector returned at $FFFE/$FFFF.
REQ-004 The block SHALL expose parameter NMI_PULSE, default 8'd15, NMI low width in clocks (legal 1..255).
REQ-005 clk_ph2  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 Addr_bus  input  16  CPU address.
REQ-008 Data_bus_out  input  8  CPU write data.
REQ-009 R_nW  input  1  1 = CPU read, 0 = CPU write.
REQ-010 Data_bus_in  output  8  read data to CPU.
REQ-011 irq  output  1  interrupt request, active-low.
REQ-012 nmi  output  1  non-maskable interrupt, active-low.

Function
REQ-013 Read data SHALL be combinational from Addr_bus (zero-cycle latency); writes SHALL commit on the clk_ph2 edge when R_nW=0.
REQ-014 $0000-$1FFF SHALL map to 2 KiB RAM, address bits [10:0], mirrored every $0800; RAM contents undefined after reset.
REQ-015 $FFFA-$FFFF SHALL return the vector parameters, low byte at even address; writes ignored.
REQ-016 $4020/$4021 SHALL be read/write reload low/high bytes (RELOAD[15:0]).
REQ-017 $4022 CTRL: bit0 EN, bit1 AUTO, bit2 IEN; bits 7:3 read 0; writing EN=1 SHALL load COUNT<=RELOAD on that edge.
REQ-018 While EN=1 and COUNT!=0, COUNT SHALL decrement by 1 per clock.
REQ-019 When EN=1 and COUNT==0: PEND<=1; AUTO=1 -> COUNT<=RELOAD, EN stays 1; AUTO=0 -> EN<=0.
REQ-020 RELOAD=0 with AUTO=1 SHALL set PEND every clock while enabled.
REQ-021 $4023 read SHALL return {PEND,7'b0}; any write to $4023 SHALL clear PEND.
REQ-022 Clear-write and expiry on the same edge: PEND SHALL end at 1 (expiry wins).
REQ-023 irq SHALL equal ~(PEND & IEN), registered output; IEN=0 masks but does not clear PEND.
REQ-024 Any write to $4024 SHALL load an 8-bit NMI counter with NMI_PULSE; nmi SHALL be 0 while counter!=0, counter decrements per clock.
REQ-025 A $4024 write during an active pulse SHALL reload the counter (pulse extended, no high glitch).
REQ-026 $4024 reads, and all unmapped addresses, SHALL return 8'h00; unmapped writes ignored.

Reset
REQ-027 On rst=0, asynchronously: RELOAD=0, COUNT=0, EN=AUTO=IEN=0, PEND=0, NMI counter=0, irq=1, nmi=1.
REQ-028 Reset mid-count or mid-pulse SHALL abort immediately; no irq/nmi assertion on release.
REQ-029 First writes SHALL be accepted on the first clk_ph2 edge after rst rises.

Configuration
REQ-030 Macro CPU_BUS_RESPONDER_TIMER_EN defined: timer (REQ-016..REQ-023) compiled in.
REQ-031 Macro undefined: no timer logic; $4020-$4023 read 8'h00, writes ignored, irq tied 1; RAM, vectors, NMI unaffected.

Verification
REQ-032 Write $55 to $0012, read $0812/$1812 -> $55 both; read $2000 -> $00.
REQ-033 Read $FFFA..$FFFF with defaults -> $00,$20,$00,$00,$00,$20.
REQ-034 RELOAD=$0003, CTRL=$05 -> irq=0 exactly 4 clocks after CTRL edge, EN reads 0; write $4023 -> irq=1 next edge.
REQ-035 RELOAD=$0001, CTRL=$07, clear-write on expiry edge -> PEND remains 1, irq stays 0.
REQ-036 Write $4024 -> nmi=0 for 15 clocks then 1; second write at clock 10 -> nmi low for 25 clocks total.
REQ-037 Reset asserted mid-count with IEN=1 -> irq=1, CTRL reads $00, irq never asserts after release; repeat built without macro -> irq constant 1.
